// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the NCH upstream sram-like channels, the single
// downstream sram-like port and the busy flag of sram_arbiter.
// Ports: s_* per-channel request/response (packed [NCH-1:0][...]), m_* downstream, busy.
// Modports: slave = arbiter side, master = channel/memory side (testbench).
interface sram_arbiter_if #(
  parameter int NCH = 2
);
  // upstream channels
  logic [NCH-1:0]        s_req;
  logic [NCH-1:0]        s_wr;
  logic [NCH-1:0][1:0]   s_size;
  logic [NCH-1:0][3:0]   s_wstrb;
  logic [NCH-1:0][31:0]  s_addr;
  logic [NCH-1:0][31:0]  s_wdata;
  logic [NCH-1:0]        s_addr_ok;
  logic [NCH-1:0]        s_data_ok;
  logic [NCH-1:0][31:0]  s_rdata;
  // downstream port
  logic                  m_req;
  logic                  m_wr;
  logic [1:0]            m_size;
  logic [3:0]            m_wstrb;
  logic [31:0]           m_addr;
  logic [31:0]           m_wdata;
  logic                  m_addr_ok;
  logic                  m_data_ok;
  logic [31:0]           m_rdata;
  // status
  logic                  busy;

  modport slave (
    input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output s_addr_ok, s_data_ok, s_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output busy
  );

  modport master (
    output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  s_addr_ok, s_data_ok, s_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: muxes NCH sram-like channels onto one downstream port, routes responses by ID.
// Latency: zero added cycles on request path and response path (pure combinational forwarding).
// Backpressure: grant locks while m_addr_ok is low; m_req drops when OUTST IDs are outstanding.
// Ports: clk, rst (sync, active-high), bus (sram_arbiter_if.slave: s_* channels, m_* port, busy).
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed
// priority (lowest channel index wins) with no rr pointer.
module sram_arbiter #(
  parameter int NCH   = 2,
  parameter int OUTST = 4
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW  = $clog2(OUTST) + 1;

  typedef logic [IDW-1:0] id_t;

  // ST_LOCKED: an address beat was presented but not accepted; the grant is frozen.
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_e;

  lock_e          lock_q, lock_d;
  id_t            lock_id_q, lock_id_d;
  id_t            fifo_q [OUTST];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

  id_t            pick;
  id_t            gnt;
  id_t            head;
  logic           full;
  logic           m_req;
  logic           push;
  logic           pop;

  // ------------------------------------------------------------------
  // Arbitration among channels currently requesting
  // ------------------------------------------------------------------
`ifdef SRAM_ARB_RR_EN
  id_t  rr_q, rr_d;
  logic found;
  int   idx;

  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_q) + k) % NCH;
      if (!found && bus.s_req[IDW'(idx)]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the channel that completed an address beat.
  always_comb begin
    rr_d = rr_q;
    if (push) begin
      rr_d = (gnt == IDW'(NCH - 1)) ? '0 : gnt + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.s_req[IDW'(k)]) begin
        pick = IDW'(k);
      end
    end
  end
`endif

  // ------------------------------------------------------------------
  // Grant, forwarding and handshake decode
  // ------------------------------------------------------------------
  // Full is taken from the registered count only, so a same-cycle pop never
  // lets a new address beat through.
  assign full = (count_q == CW'(OUTST));
  assign gnt  = (lock_q == ST_LOCKED) ? lock_id_q : pick;
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    m_req     = bus.s_req[gnt] & ~full & ~rst;
    push      = m_req & bus.m_addr_ok;
    pop       = bus.m_data_ok & (count_q != '0) & ~rst;

    lock_d    = (m_req && !bus.m_addr_ok) ? ST_LOCKED : ST_OPEN;
    lock_id_d = gnt;
    count_d   = count_q + CW'(push) - CW'(pop);

    bus.m_req     = m_req;
    bus.m_wr      = bus.s_wr[gnt];
    bus.m_size    = bus.s_size[gnt];
    bus.m_wstrb   = bus.s_wstrb[gnt];
    bus.m_addr    = bus.s_addr[gnt];
    bus.m_wdata   = bus.s_wdata[gnt];

    bus.s_addr_ok = '0;
    if (push) begin
      bus.s_addr_ok[gnt] = 1'b1;
    end

    // Read data is broadcast; only the owner sees s_data_ok.
    bus.s_data_ok = '0;
    if (pop) begin
      bus.s_data_ok[head] = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      bus.s_rdata[c] = bus.m_rdata;
    end

    bus.busy = ~rst & (count_q != '0);
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= ST_OPEN;
      lock_id_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      count_q   <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= gnt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors for sram_arbiter (NCH=2, OUTST=4).
// Inputs change 1ns after the rising edge, outputs are compared 3ns later.
// Prints one summary line at the end.
module tb_sram_arbiter;

  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if #(.NCH(NCH)) bus ();

  sram_arbiter #(
    .NCH   (NCH),
    .OUTST (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and let combinational paths settle.
  task automatic drive(input logic [1:0] req, input logic aok, input logic dok,
                       input logic [31:0] rdata);
    bus.s_req     = req;
    bus.m_addr_ok = aok;
    bus.m_data_ok = dok;
    bus.m_rdata   = rdata;
    #3;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int          exp_g;
  int          prev_g;
  int          ord_id [4] = '{0, 1, 1, 0};
  logic [31:0] ord_rd [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    rst            = 1'b1;
    bus.s_req      = '0;
    bus.s_wr       = '0;
    bus.s_size     = '0;
    bus.s_wstrb    = '0;
    bus.s_wdata    = '0;
    bus.s_addr[0]  = 32'h0000_0100;
    bus.s_addr[1]  = 32'h0000_0200;
    bus.m_addr_ok  = 1'b0;
    bus.m_data_ok  = 1'b0;
    bus.m_rdata    = '0;
    prev_g         = 0;
    exp_g          = 0;

    // ---------------- reset state ----------------
    #1;
    drive(2'b11, 1'b1, 1'b1, 32'h0);
    check("rst_mreq", bus.m_req, 1'b0);
    check("rst_aok", bus.s_addr_ok, 2'b00);
    check("rst_dok", bus.s_data_ok, 2'b00);
    tick();
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    tick();

    // ---------------- both channels requesting every cycle ----------------
    for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
      exp_g = k % 2;
`else
      exp_g = 0;
`endif
      drive(2'b11, 1'b1, (k > 0), 32'(k));
      check("arb_aok", bus.s_addr_ok, 2'b01 << exp_g);
      check("arb_addr", bus.m_addr, (exp_g == 0) ? 32'h100 : 32'h200);
      if (k > 0) check("arb_dok", bus.s_data_ok, 2'b01 << prev_g);
      prev_g = exp_g;
      tick();
    end
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    check("arb_dok_last", bus.s_data_ok, 2'b01 << prev_g);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("arb_idle_busy", bus.busy, 1'b0);
    tick();

    // ---------------- lock while m_addr_ok low ----------------
    bus.s_addr[1] = 32'h1C00_0010;
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    check("lock_addr0", bus.m_addr, 32'h1C00_0010);
    check("lock_mreq0", bus.m_req, 1'b1);
    tick();
    for (int k = 1; k < 3; k++) begin
      drive(2'b11, 1'b0, 1'b0, 32'h0);
      check("lock_addr_hold", bus.m_addr, 32'h1C00_0010);
      check("lock_aok_none", bus.s_addr_ok, 2'b00);
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("lock_addr3", bus.m_addr, 32'h1C00_0010);
    check("lock_gnt_ch1", bus.s_addr_ok, 2'b10);
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    check("lock_gnt_ch0", bus.s_addr_ok, 2'b01);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    check("lock_dok1", bus.s_data_ok, 2'b10);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    check("lock_dok0", bus.s_data_ok, 2'b01);
    tick();
    bus.s_addr[1] = 32'h0000_0200;

    // ---------------- full: 4 outstanding, data_ok held low ----------------
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    check("full_aok_first", bus.s_addr_ok, 2'b10);
    tick();
    for (int k = 1; k < 4; k++) begin
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      check("full_aok_fill", bus.s_addr_ok, 2'b01);
      tick();
    end
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    check("full_mreq", bus.m_req, 1'b0);
    check("full_aok_none", bus.s_addr_ok, 2'b00);
    check("full_busy", bus.busy, 1'b1);
    tick();
    drive(2'b01, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("full_mreq_pop", bus.m_req, 1'b0);
    check("full_dok", bus.s_data_ok, 2'b10);
    check("full_rdata", bus.s_rdata[1], 32'hDEAD_BEEF);
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    check("full_mreq_back", bus.m_req, 1'b1);
    check("full_aok_back", bus.s_addr_ok, 2'b01);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 1'b0, 1'b1, 32'h0);
      check("full_drain_dok", bus.s_data_ok, 2'b01);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("full_drain_busy", bus.busy, 1'b0);
    tick();

    // ---------------- response ordering 0,1,1,0 ----------------
    for (int k = 0; k < 4; k++) begin
      drive(2'b01 << ord_id[k], 1'b1, 1'b0, 32'h0);
      check("ord_aok", bus.s_addr_ok, 2'b01 << ord_id[k]);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 1'b0, 1'b1, ord_rd[k]);
      check("ord_dok", bus.s_data_ok, 2'b01 << ord_id[k]);
      check("ord_rdata", bus.s_rdata[ord_id[k]], ord_rd[k]);
      tick();
    end

    // ---------------- spurious data_ok with nothing outstanding ----------------
    drive(2'b00, 1'b0, 1'b1, 32'h55);
    check("spur_dok", bus.s_data_ok, 2'b00);
    check("spur_busy", bus.busy, 1'b0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("spur_busy_after", bus.busy, 1'b0);
    tick();

    // ---------------- reset with 3 outstanding ----------------
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("mrst_busy_pre", bus.busy, 1'b1);
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'h0);
    check("mrst_mreq", bus.m_req, 1'b0);
    check("mrst_aok", bus.s_addr_ok, 2'b00);
    check("mrst_dok", bus.s_data_ok, 2'b00);
    tick();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("mrst_busy_post", bus.busy, 1'b0);
    tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    check("mrst_fresh_aok", bus.s_addr_ok, 2'b10);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h77);
    check("mrst_fresh_dok", bus.s_data_ok, 2'b10);
    check("mrst_fresh_rdata", bus.s_rdata[1], 32'h77);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("mrst_end_busy", bus.busy, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
